fx2_slave_fifo_responder: RTL and testbench
===========================================

Name: fx2_slave_fifo_responder

Overview:
- Synthesizable responder for the FX2 Slave FIFO interface. It is the device-side end that hs_io_v2 drives as master.
- Models two endpoints:
  - EP6: host->FPGA, read by the master via SLRD.
  - EP2: FPGA->host, written by the master via SLWR and committed in packets.
- Used for on-chip loopback self-test and for the hs_io_v2 bench. The host side is exposed as plain FIFO ports on the same clock.

Parameters:
- DEPTH_LOG2, 10, log2 of each endpoint buffer depth in 16-bit words.
- PKT_WORDS, 256, auto-commit size of an EP2 packet (512 bytes).
- PF_LEVEL, 64, FLAGA asserts when EP2 free space < PF_LEVEL words.

Ports:
- IFCLK  in  1  sole clock; all I/O sampled on its rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- FIFOADR  in  2  endpoint select: 2'b00=EP2, 2'b10=EP6, others invalid.
- SLRD  in  1  active-low read strobe.
- SLWR  in  1  active-low write strobe.
- SLOE  in  1  active-low output enable.
- PKTEND  in  1  active-low packet-end strobe.
- FIFO_DATA_IN  in  16  write data from master.
- FIFO_DATA_OUT  out  16  head word of EP6.
- FIFO_DATA_OE  out  1  drive enable for the external bus.
- FLAGA  out  1  active-low EP2 programmable-full.
- FLAGB  out  1  active-low FULL of the addressed endpoint.
- FLAGC  out  1  active-low EMPTY of the addressed endpoint.
- host_din  in  16  host data into EP6.
- host_wr_en  in  1  EP6 write.
- host_full  out  1  EP6 full.
- host_dout  out  16  committed EP2 head word (first-word-fall-through).
- host_rd_en  in  1  EP2 read.
- host_empty  out  1  no committed EP2 words.
- err_flags  out  3  sticky error bits: {protocol, overrun, underrun}.

Behaviour:
Reset
- Both buffers empty, pointers zero, uncommitted count zero.
- FLAGA=1, FLAGB=1, FLAGC=0 (empty), FIFO_DATA_OE=0, FIFO_DATA_OUT=0, host_full=0, host_empty=1, err_flags=0.
- Reset mid-operation discards all data, including uncommitted EP2 words.

EP6 read path
- FIFO_DATA_OUT is always the EP6 head word.
- FIFO_DATA_OE = !SLOE && FIFOADR==2'b10. It is combinational; it is the only combinational output.
- At an edge with SLRD=0, FIFOADR=2'b10 and EP6 non-empty: pop one word. The next word appears one cycle later.
- SLRD=0 while EP6 is empty: no pop; set err underrun.

EP2 write path
- At an edge with SLWR=0, FIFOADR=2'b00 and EP2 not full: push FIFO_DATA_IN; uncommitted count +1.
- SLWR=0 while EP2 is full: word dropped; set err overrun.
- "Full" counts committed plus uncommitted words against the depth 2^DEPTH_LOG2.

Commit state machine
- States: IDLE (uncommitted=0) and FILL (uncommitted>0).
- A commit happens at an edge when either condition holds:
  - the uncommitted count reaches PKT_WORDS (including a word pushed that cycle), or
  - PKTEND=0 with FIFOADR=2'b00.
- A word pushed in the same cycle as PKTEND is included in the committed packet.
- On commit, all uncommitted words become visible to the host on the next cycle; the state returns to IDLE.
- PKTEND in IDLE: zero-length packet; no data effect, no error.
- host_rd_en while host_empty=1: ignored.

Protocol errors (set err protocol; no buffer effect)
- SLRD=0 with FIFOADR=2'b00.
- SLWR=0 with FIFOADR=2'b10.
- SLRD=0 and SLWR=0 in the same cycle.

Flags
- Registered; they reflect buffer state after the current edge's operations, for the FIFOADR sampled at that edge.
- Invalid FIFOADR gives FLAGB=0 and FLAGC=0 (full and empty both asserted).
- host_full and host_empty are registered in the same way.

Simultaneous access
- Host push to EP6 and master pop from EP6 in the same cycle: both take effect; count unchanged.
- Host pop from EP2 and master push to EP2 in the same cycle: both take effect.
- Pointer arithmetic wraps modulo 2^DEPTH_LOG2; counts are DEPTH_LOG2+1 bits.
- err_flags are cleared only by reset.

Optional Feature:
- Macro: FX2_RESPONDER_LOOPBACK_EN.
- When defined:
  - Adds input loopback (1 bit).
  - While loopback=1, each cycle one committed EP2 word moves into EP6 if EP2 is non-empty and EP6 is not full.
  - host_wr_en and host_rd_en are ignored; host_empty=1 and host_full=1.
- When undefined:
  - The port is absent and no loopback logic exists.

Test Plan:
1. Reset, then host writes 0x0001..0x0004 to EP6; master holds FIFOADR=2'b10, SLOE=0, pulses SLRD four times -> FIFO_DATA_OUT sequence 0x0001..0x0004; FLAGC goes 0 the cycle after the 4th pop; err_flags=0.
2. Master writes 255 words to EP2 -> host_empty stays 1. 256th write -> host_empty=0 the next cycle; host reads 256 words in order.
3. Master writes 3 words, then PKTEND=0 together with a 4th word -> exactly 4 words visible to host; then PKTEND in IDLE -> no change, err_flags=0.
4. Fill EP2 to 1024 words -> FLAGB=0; FLAGA=0 from 961 words; 1025th SLWR -> word dropped, err_flags=3'b010.
5. SLRD=0 on empty EP6 -> err_flags[0]=1. SLWR=0 with FIFOADR=2'b10 -> err_flags[2]=1. FIFOADR=2'b01 -> FLAGB=0 and FLAGC=0.
6. With FX2_RESPONDER_LOOPBACK_EN and loopback=1: write 10 words, then PKTEND -> the same 10 words readable via SLRD from EP6 in order; RESET_N low mid-transfer -> all flags return to reset values.

Source files
------------

// File: rtl/fx2_slave_fifo_responder.sv
// Device-side responder for the FX2 Slave FIFO bus: EP6 (host->master) and packetised EP2 (master->host).
// Optional macro FX2_RESPONDER_LOOPBACK_EN adds a loopback input that moves committed EP2 words into EP6.
module fx2_slave_fifo_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned PKT_WORDS  = 256,
    parameter int unsigned PF_LEVEL   = 64
) (
    input  logic        IFCLK,
    input  logic        RESET_N,
    input  logic [1:0]  FIFOADR,
    input  logic        SLRD,
    input  logic        SLWR,
    input  logic        SLOE,
    input  logic        PKTEND,
    input  logic [15:0] FIFO_DATA_IN,
    output logic [15:0] FIFO_DATA_OUT,
    output logic        FIFO_DATA_OE,
    output logic        FLAGA,
    output logic        FLAGB,
    output logic        FLAGC,
    input  logic [15:0] host_din,
    input  logic        host_wr_en,
    output logic        host_full,
    output logic [15:0] host_dout,
    input  logic        host_rd_en,
    output logic        host_empty,
    output logic [2:0]  err_flags
`ifdef FX2_RESPONDER_LOOPBACK_EN
    ,
    input  logic        loopback
`endif
);

    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t          state, state_n;
    logic [15:0]     ep6_mem [DEPTH];
    logic [15:0]     ep2_mem [DEPTH];
    logic [AW-1:0]   ep6_wr, ep6_rd, ep2_wr, ep2_rd;
    logic [AW-1:0]   ep6_wr_n, ep6_rd_n, ep2_wr_n, ep2_rd_n;
    logic [CW-1:0]   ep6_cnt, ep6_cnt_n;
    logic [CW-1:0]   ep2_cnt, ep2_cnt_n;   // committed EP2 words
    logic [CW-1:0]   ep2_unc, ep2_unc_n;   // pushed but not yet committed
    logic [CW-1:0]   ep2_total, ep2_total_n, unc_inc;
    logic [15:0]     ep6_head_n, ep2_head_n, ep6_din;

    logic sel_ep2, sel_ep6, rd_req, wr_req;
    logic proto_err, underrun, overrun;
    logic m_pop, m_push, h_push, h_pop, ep6_push, commit;
    logic lb_move, host_en;
    logic flaga_n, flagb_n, flagc_n, host_full_n, host_empty_n;

`ifdef FX2_RESPONDER_LOOPBACK_EN
    assign lb_move = loopback && (ep2_cnt != '0) && (ep6_cnt != CW'(DEPTH));
    assign host_en = !loopback;
`else
    assign lb_move = 1'b0;
    assign host_en = 1'b1;
`endif

    assign FIFO_DATA_OE = !SLOE && (FIFOADR == 2'b10);

    // Strobe decode and per-edge buffer operations
    always_comb begin
        sel_ep2   = (FIFOADR == 2'b00);
        sel_ep6   = (FIFOADR == 2'b10);
        rd_req    = !SLRD;
        wr_req    = !SLWR;
        ep2_total = ep2_cnt + ep2_unc;

        proto_err = (rd_req && sel_ep2) || (wr_req && sel_ep6) || (rd_req && wr_req);
        m_pop     = rd_req && !wr_req && sel_ep6 && (ep6_cnt != '0);
        underrun  = rd_req && !wr_req && sel_ep6 && (ep6_cnt == '0);
        m_push    = wr_req && !rd_req && sel_ep2 && (ep2_total != CW'(DEPTH));
        overrun   = wr_req && !rd_req && sel_ep2 && (ep2_total == CW'(DEPTH));

        h_push    = host_en && host_wr_en && (ep6_cnt != CW'(DEPTH));
        h_pop     = (host_en && host_rd_en && (ep2_cnt != '0)) || lb_move;
        ep6_push  = h_push || lb_move;
        ep6_din   = lb_move ? host_dout : host_din;

        // A PKTEND in IDLE with no word this cycle is a zero-length packet
        unc_inc   = ep2_unc + CW'(m_push);
        commit    = (unc_inc == CW'(PKT_WORDS)) ||
                    (!PKTEND && sel_ep2 && ((state == FILL) || m_push));
        state_n   = IDLE;
        if (!commit && (unc_inc != '0)) state_n = FILL;

        ep6_wr_n  = ep6_wr + AW'(ep6_push);
        ep6_rd_n  = ep6_rd + AW'(m_pop);
        ep6_cnt_n = ep6_cnt + CW'(ep6_push) - CW'(m_pop);
        ep2_wr_n  = ep2_wr + AW'(m_push);
        ep2_rd_n  = ep2_rd + AW'(h_pop);
        ep2_unc_n = commit ? '0 : unc_inc;
        ep2_cnt_n = ep2_cnt - CW'(h_pop) + (commit ? unc_inc : '0);
        ep2_total_n = ep2_cnt_n + ep2_unc_n;

        // Head words bypass the memory when the word written this edge becomes the head
        ep6_head_n = ep6_mem[ep6_rd_n];
        if (ep6_push && (ep6_wr == ep6_rd_n)) ep6_head_n = ep6_din;
        if (ep6_cnt_n == '0) ep6_head_n = '0;
        ep2_head_n = ep2_mem[ep2_rd_n];
        if (m_push && (ep2_wr == ep2_rd_n)) ep2_head_n = FIFO_DATA_IN;

        flaga_n = !(ep2_total_n > CW'(DEPTH - PF_LEVEL));
        flagb_n = 1'b0;
        flagc_n = 1'b0;
        if (sel_ep2) begin
            flagb_n = (ep2_total_n != CW'(DEPTH));
            flagc_n = (ep2_total_n != '0);
        end else if (sel_ep6) begin
            flagb_n = (ep6_cnt_n != CW'(DEPTH));
            flagc_n = (ep6_cnt_n != '0);
        end
        host_full_n  = !host_en || (ep6_cnt_n == CW'(DEPTH));
        host_empty_n = !host_en || (ep2_cnt_n == '0);
    end

    always_ff @(posedge IFCLK) begin
        if (ep6_push) ep6_mem[ep6_wr] <= ep6_din;
        if (m_push)   ep2_mem[ep2_wr] <= FIFO_DATA_IN;
    end

    // Pointers, counts, commit state and registered outputs
    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            ep6_wr        <= '0;
            ep6_rd        <= '0;
            ep2_wr        <= '0;
            ep2_rd        <= '0;
            ep6_cnt       <= '0;
            ep2_cnt       <= '0;
            ep2_unc       <= '0;
            FIFO_DATA_OUT <= '0;
            host_dout     <= '0;
            FLAGA         <= 1'b1;
            FLAGB         <= 1'b1;
            FLAGC         <= 1'b0;
            host_full     <= 1'b0;
            host_empty    <= 1'b1;
            err_flags     <= '0;
        end else begin
            state         <= state_n;
            ep6_wr        <= ep6_wr_n;
            ep6_rd        <= ep6_rd_n;
            ep2_wr        <= ep2_wr_n;
            ep2_rd        <= ep2_rd_n;
            ep6_cnt       <= ep6_cnt_n;
            ep2_cnt       <= ep2_cnt_n;
            ep2_unc       <= ep2_unc_n;
            FIFO_DATA_OUT <= ep6_head_n;
            host_dout     <= ep2_head_n;
            FLAGA         <= flaga_n;
            FLAGB         <= flagb_n;
            FLAGC         <= flagc_n;
            host_full     <= host_full_n;
            host_empty    <= host_empty_n;
            err_flags     <= err_flags | {proto_err, overrun, underrun};
        end
    end

endmodule

// File: tb/tb_fx2_slave_fifo_responder.sv
// Directed bench for fx2_slave_fifo_responder: vector table for EP6/flags/errors, hand sequences for EP2 packets.
module tb_fx2_slave_fifo_responder;

    logic        IFCLK = 1'b0;
    logic        RESET_N;
    logic [1:0]  FIFOADR;
    logic        SLRD, SLWR, SLOE, PKTEND;
    logic [15:0] FIFO_DATA_IN, FIFO_DATA_OUT;
    logic        FIFO_DATA_OE, FLAGA, FLAGB, FLAGC;
    logic [15:0] host_din, host_dout;
    logic        host_wr_en, host_full, host_rd_en, host_empty;
    logic [2:0]  err_flags;
`ifdef FX2_RESPONDER_LOOPBACK_EN
    logic        loopback;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 IFCLK = ~IFCLK;

    fx2_slave_fifo_responder dut (
        .IFCLK(IFCLK), .RESET_N(RESET_N), .FIFOADR(FIFOADR),
        .SLRD(SLRD), .SLWR(SLWR), .SLOE(SLOE), .PKTEND(PKTEND),
        .FIFO_DATA_IN(FIFO_DATA_IN), .FIFO_DATA_OUT(FIFO_DATA_OUT),
        .FIFO_DATA_OE(FIFO_DATA_OE), .FLAGA(FLAGA), .FLAGB(FLAGB), .FLAGC(FLAGC),
        .host_din(host_din), .host_wr_en(host_wr_en), .host_full(host_full),
        .host_dout(host_dout), .host_rd_en(host_rd_en), .host_empty(host_empty),
        .err_flags(err_flags)
`ifdef FX2_RESPONDER_LOOPBACK_EN
        , .loopback(loopback)
`endif
    );

    typedef struct packed {
        logic [1:0]  adr;
        logic        slrd, slwr, sloe, hwr;
        logic [15:0] hdin;
        logic        e_flagb, e_flagc, e_oe, e_hempty;
        logic [2:0]  e_err;
        logic        cd;
        logic [15:0] e_dout;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic [1:0] adr, input logic slrd, input logic slwr,
                                input logic sloe, input logic hwr, input logic [15:0] hdin,
                                input logic fb, input logic fc, input logic oe,
                                input logic [2:0] err, input logic cd, input logic [15:0] dout);
        vec_t v;
        v = '{adr: adr, slrd: slrd, slwr: slwr, sloe: sloe, hwr: hwr, hdin: hdin,
              e_flagb: fb, e_flagc: fc, e_oe: oe, e_hempty: 1'b1, e_err: err, cd: cd, e_dout: dout};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge IFCLK);
        #1;
    endtask

    task automatic idle(input logic [1:0] adr);
        FIFOADR = adr; SLRD = 1'b1; SLWR = 1'b1; SLOE = 1'b0; PKTEND = 1'b1;
        FIFO_DATA_IN = '0; host_din = '0; host_wr_en = 1'b0; host_rd_en = 1'b0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        idle(2'b10);
        SLOE = 1'b1;
        step();
        step();
        RESET_N = 1'b1;
        SLOE = 1'b0;
    endtask

    task automatic reset_state_checks(input string tag);
        chk({tag, "_flaga"}, 32'(FLAGA), 1);
        chk({tag, "_flagb"}, 32'(FLAGB), 1);
        chk({tag, "_flagc"}, 32'(FLAGC), 0);
        chk({tag, "_dout"}, 32'(FIFO_DATA_OUT), 0);
        chk({tag, "_hfull"}, 32'(host_full), 0);
        chk({tag, "_hempty"}, 32'(host_empty), 1);
        chk({tag, "_err"}, 32'(err_flags), 0);
    endtask

    initial begin
        int bad;
`ifdef FX2_RESPONDER_LOOPBACK_EN
        loopback = 1'b0;
`endif
        RESET_N = 1'b0;
        idle(2'b10);
        SLOE = 1'b1;
        #1;
        chk("rst_oe", 32'(FIFO_DATA_OE), 0);
        step();
        reset_state_checks("rst");
        step();
        RESET_N = 1'b1;
        SLOE = 1'b0;

        // EP6 fill/drain, underrun, protocol errors, invalid address
        vecs[0]  = mk(2'b10, 1, 1, 0, 1, 16'h0001, 1, 1, 1, 3'b000, 1, 16'h0001);
        vecs[1]  = mk(2'b10, 1, 1, 0, 1, 16'h0002, 1, 1, 1, 3'b000, 1, 16'h0001);
        vecs[2]  = mk(2'b10, 1, 1, 0, 1, 16'h0003, 1, 1, 1, 3'b000, 1, 16'h0001);
        vecs[3]  = mk(2'b10, 1, 1, 0, 1, 16'h0004, 1, 1, 1, 3'b000, 1, 16'h0001);
        vecs[4]  = mk(2'b10, 0, 1, 0, 0, 16'h0000, 1, 1, 1, 3'b000, 1, 16'h0002);
        vecs[5]  = mk(2'b10, 0, 1, 0, 0, 16'h0000, 1, 1, 1, 3'b000, 1, 16'h0003);
        vecs[6]  = mk(2'b10, 0, 1, 0, 0, 16'h0000, 1, 1, 1, 3'b000, 1, 16'h0004);
        vecs[7]  = mk(2'b10, 0, 1, 0, 0, 16'h0000, 1, 0, 1, 3'b000, 0, 16'h0000);
        vecs[8]  = mk(2'b10, 0, 1, 0, 0, 16'h0000, 1, 0, 1, 3'b001, 0, 16'h0000);
        vecs[9]  = mk(2'b10, 1, 0, 0, 0, 16'h0000, 1, 0, 1, 3'b101, 0, 16'h0000);
        vecs[10] = mk(2'b01, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 3'b101, 0, 16'h0000);
        vecs[11] = mk(2'b00, 1, 1, 0, 0, 16'h0000, 1, 0, 0, 3'b101, 0, 16'h0000);
        vecs[12] = mk(2'b10, 1, 1, 1, 0, 16'h0000, 1, 0, 0, 3'b101, 0, 16'h0000);

        for (int i = 0; i < 13; i++) begin
            idle(vecs[i].adr);
            SLRD = vecs[i].slrd; SLWR = vecs[i].slwr; SLOE = vecs[i].sloe;
            host_wr_en = vecs[i].hwr; host_din = vecs[i].hdin;
            step();
            chk($sformatf("v%0d_flagb", i), 32'(FLAGB), 32'(vecs[i].e_flagb));
            chk($sformatf("v%0d_flagc", i), 32'(FLAGC), 32'(vecs[i].e_flagc));
            chk($sformatf("v%0d_oe", i), 32'(FIFO_DATA_OE), 32'(vecs[i].e_oe));
            chk($sformatf("v%0d_hempty", i), 32'(host_empty), 32'(vecs[i].e_hempty));
            chk($sformatf("v%0d_err", i), 32'(err_flags), 32'(vecs[i].e_err));
            if (vecs[i].cd) chk($sformatf("v%0d_dout", i), 32'(FIFO_DATA_OUT), 32'(vecs[i].e_dout));
        end

        // Auto-commit at 256 words
        do_reset();
        idle(2'b00);
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            SLWR = 1'b0; FIFO_DATA_IN = 16'(16'h1000 + i);
            step();
            if (host_empty !== 1'b1) bad++;
        end
        chk("t2_pre_commit_empty", 32'(bad), 0);
        FIFO_DATA_IN = 16'h10FF;
        step();
        SLWR = 1'b1;
        chk("t2_commit_visible", 32'(host_empty), 0);
        bad = 0;
        host_rd_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (host_dout !== 16'(16'h1000 + i)) bad++;
            step();
        end
        host_rd_en = 1'b0;
        chk("t2_read_order", 32'(bad), 0);
        chk("t2_drained", 32'(host_empty), 1);
        chk("t2_err", 32'(err_flags), 0);

        // Short packet: PKTEND together with the 4th word
        for (int i = 0; i < 3; i++) begin
            SLWR = 1'b0; FIFO_DATA_IN = 16'(16'h00A0 + i);
            step();
        end
        chk("t3_uncommitted_hidden", 32'(host_empty), 1);
        FIFO_DATA_IN = 16'h00A3; PKTEND = 1'b0;
        step();
        SLWR = 1'b1; PKTEND = 1'b1;
        chk("t3_commit_visible", 32'(host_empty), 0);
        bad = 0;
        host_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (host_dout !== 16'(16'h00A0 + i)) bad++;
            step();
        end
        host_rd_en = 1'b0;
        chk("t3_read_order", 32'(bad), 0);
        chk("t3_exactly_four", 32'(host_empty), 1);
        PKTEND = 1'b0;
        step();
        PKTEND = 1'b1;
        chk("t3_zlp_empty", 32'(host_empty), 1);
        chk("t3_zlp_flagc", 32'(FLAGC), 0);
        chk("t3_zlp_err", 32'(err_flags), 0);

        // Fill EP2 to full, programmable-full threshold, overrun
        do_reset();
        idle(2'b00);
        bad = 0;
        for (int k = 1; k <= 1024; k++) begin
            SLWR = 1'b0; FIFO_DATA_IN = 16'(k - 1);
            step();
            if (FLAGA !== ((k >= 961) ? 1'b0 : 1'b1)) bad++;
            if (FLAGB !== ((k == 1024) ? 1'b0 : 1'b1)) bad++;
            if (k == 960) chk("t4_flaga_960", 32'(FLAGA), 1);
            if (k == 961) chk("t4_flaga_961", 32'(FLAGA), 0);
        end
        chk("t4_flag_walk", 32'(bad), 0);
        chk("t4_flagb_full", 32'(FLAGB), 0);
        chk("t4_err_before", 32'(err_flags), 0);
        FIFO_DATA_IN = 16'hDEAD;
        step();
        SLWR = 1'b1;
        chk("t4_overrun_err", 32'(err_flags), 32'b010);
        chk("t4_still_full", 32'(FLAGB), 0);
        bad = 0;
        host_rd_en = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            if (host_dout !== 16'(i)) bad++;
            step();
        end
        host_rd_en = 1'b0;
        chk("t4_read_order", 32'(bad), 0);
        chk("t4_dropped_word", 32'(host_empty), 1);

`ifdef FX2_RESPONDER_LOOPBACK_EN
        // Loopback: committed EP2 words reappear on EP6
        do_reset();
        idle(2'b00);
        loopback = 1'b1;
        for (int i = 0; i < 10; i++) begin
            SLWR = 1'b0; FIFO_DATA_IN = 16'(16'h0050 + i);
            step();
        end
        SLWR = 1'b1; PKTEND = 1'b0;
        step();
        PKTEND = 1'b1; FIFOADR = 2'b10;
        repeat (12) step();
        chk("t6_ep6_nonempty", 32'(FLAGC), 1);
        chk("t6_hfull", 32'(host_full), 1);
        chk("t6_hempty", 32'(host_empty), 1);
        bad = 0;
        SLRD = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (FIFO_DATA_OUT !== 16'(16'h0050 + i)) bad++;
            step();
        end
        SLRD = 1'b1;
        chk("t6_lb_order", 32'(bad), 0);
        chk("t6_ep6_drained", 32'(FLAGC), 0);
        chk("t6_err", 32'(err_flags), 0);
        FIFOADR = 2'b00;
        for (int i = 0; i < 5; i++) begin
            SLWR = 1'b0; FIFO_DATA_IN = 16'(16'h0070 + i);
            step();
        end
        SLWR = 1'b1; PKTEND = 1'b0;
        step();
        PKTEND = 1'b1;
        step();
        RESET_N = 1'b0;
        #1;
        reset_state_checks("t6_rst");
        step();
        RESET_N = 1'b1;
        loopback = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
